// File: rtl/ru_scheduler.sv
// Recompute-unit scheduler: captures BIST fault reports, replays them to a buffer, then dispatches one RU per fault.
// Latency: N capture cycles after start, RUs run until all report done, then a single-cycle done pulse.
// Backpressure: fault_ready low outside IDLE or when the table is full. Optional macro RU_SCHED_DEDUP_EN drops duplicate reports.
module ru_scheduler #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NUM_RU = 4,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NW = $clog2(NUM_RU + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fault_valid,
    input  logic [RW-1:0]                fault_row,
    input  logic [CW-1:0]                fault_col,
    output logic                         fault_ready,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         buf_we,
    output logic [RW-1:0]                buf_row,
    output logic [CW-1:0]                buf_col,
    output logic [NUM_RU-1:0]            ru_en,
    output logic [NUM_RU-1:0][RW-1:0]    ru_row,
    output logic [NUM_RU-1:0][CW-1:0]    ru_col,
    input  logic [NUM_RU-1:0]            ru_done,
    output logic [NW-1:0]                num_faults,
    output logic                         overflow
);

    localparam int SW = (NUM_RU > 1) ? $clog2(NUM_RU) : 1;
    localparam logic [NW-1:0] FULL = NW'(NUM_RU);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMPUTE, DONE} state_t;

    state_t                      state_q, state_d;
    logic [NUM_RU-1:0][RW-1:0]   row_q, row_d;
    logic [NUM_RU-1:0][CW-1:0]   col_q, col_d;
    logic [NW-1:0]               num_q, num_d;
    logic                        ovf_q, ovf_d;
    logic [SW-1:0]               cap_q, cap_d;
    logic [NUM_RU-1:0]           lat_q, lat_d;
    logic [NUM_RU-1:0]           en_mask;
    logic                        store;
`ifdef RU_SCHED_DEDUP_EN
    logic                        dup;
`endif

    always_comb begin
        en_mask = '0;
        for (int k = 0; k < NUM_RU; k++) begin
            en_mask[k] = (NW'(k) < num_q);
        end
    end

`ifdef RU_SCHED_DEDUP_EN
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < NUM_RU; k++) begin
            if (en_mask[k] && row_q[k] == fault_row && col_q[k] == fault_col) begin
                dup = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        num_d       = num_q;
        ovf_d       = ovf_q;
        cap_d       = cap_q;
        lat_d       = lat_q;
        store       = 1'b0;
        fault_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        buf_we      = 1'b0;
        buf_row     = row_q[cap_q];
        buf_col     = col_q[cap_q];
        ru_en       = '0;
        case (state_q)
            IDLE: begin
                fault_ready = (num_q < FULL);
                if (fault_valid) begin
`ifdef RU_SCHED_DEDUP_EN
                    if (dup) begin
                        store = 1'b0;
                    end else
`endif
                    if (fault_ready) begin
                        store                    = 1'b1;
                        row_d[num_q[SW-1:0]]     = fault_row;
                        col_d[num_q[SW-1:0]]     = fault_col;
                        num_d                    = num_q + NW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // A report arriving with start joins this pass, so the empty check includes it.
                if (start) begin
                    cap_d   = '0;
                    state_d = (num_q != '0 || store) ? CAPTURE : DONE;
                end
            end
            CAPTURE: begin
                busy   = 1'b1;
                buf_we = 1'b1;
                if ((NW'(cap_q) + NW'(1)) == num_q) begin
                    cap_d   = '0;
                    state_d = COMPUTE;
                end else begin
                    cap_d = cap_q + 1'b1;
                end
            end
            COMPUTE: begin
                busy  = 1'b1;
                ru_en = en_mask & ~lat_q;
                lat_d = lat_q | (ru_done & ru_en);
                if (&(lat_q | ~en_mask)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                lat_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
            cap_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
            cap_q   <= cap_d;
            lat_q   <= lat_d;
        end
    end

    assign num_faults = num_q;
    assign overflow   = ovf_q;
    assign ru_row     = row_q;
    assign ru_col     = col_q;

endmodule

// File: tb/tb_ru_scheduler.sv
// Directed self-checking bench for ru_scheduler (default 4x4 array, 4 RUs).
// Latency: checks every cycle of capture, compute and done phases.
// Backpressure: drives fault_valid/start while busy or full and checks they are ignored.
module tb_ru_scheduler;

`ifdef RU_SCHED_DEDUP_EN
    localparam int DUP_N = 1;
`else
    localparam int DUP_N = 2;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fault_valid;
    logic [1:0]      fault_row;
    logic [1:0]      fault_col;
    logic            fault_ready;
    logic            start;
    logic            busy;
    logic            done;
    logic            buf_we;
    logic [1:0]      buf_row;
    logic [1:0]      buf_col;
    logic [3:0]      ru_en;
    logic [3:0][1:0] ru_row;
    logic [3:0][1:0] ru_col;
    logic [3:0]      ru_done;
    logic [2:0]      num_faults;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    bit finished = 1'b0;

    ru_scheduler #(.ROWS(4), .COLS(4), .NUM_RU(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fault_valid (fault_valid),
        .fault_row   (fault_row),
        .fault_col   (fault_col),
        .fault_ready (fault_ready),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .buf_we      (buf_we),
        .buf_row     (buf_row),
        .buf_col     (buf_col),
        .ru_en       (ru_en),
        .ru_row      (ru_row),
        .ru_col      (ru_col),
        .ru_done     (ru_done),
        .num_faults  (num_faults),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        repeat (2000) @(posedge clk);
        if (!finished) begin
            errors++;
            $error("FAIL timeout: wait expired before the bench finished");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        fault_valid = 1'b0; fault_row = 2'd0; fault_col = 2'd0;
        start = 1'b0; ru_done = 4'b0; rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ru_en !== 4'b0000 || buf_we !== 1'b0
            || num_faults !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $error("FAIL reset_state busy=%0b done=%0b ru_en=%0h buf_we=%0b num=%0d ovf=%0b",
                   busy, done, ru_en, buf_we, num_faults, overflow);
        end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL rst_busy observed=%0h", busy); end
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL rst_done observed=%0h", done); end
        checks++; if (num_faults !== 3'd0) begin errors++; $error("FAIL rst_num observed=%0h", num_faults); end
        checks++; if (overflow !== 1'b0) begin errors++; $error("FAIL rst_ovf observed=%0h", overflow); end
        checks++; if (fault_ready !== 1'b1) begin errors++; $error("FAIL rst_ready observed=%0h", fault_ready); end
        checks++; if (ru_en !== 4'b0000) begin errors++; $error("FAIL rst_ru_en observed=%0h", ru_en); end
        checks++; if (buf_we !== 1'b0) begin errors++; $error("FAIL rst_buf_we observed=%0h", buf_we); end
        rst_n = 1'b1;
        tick();

        // Empty table: straight to DONE.
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $error("FAIL empty_done observed=%0h", done); end
        checks++; if (busy !== 1'b1) begin errors++; $error("FAIL empty_busy observed=%0h", busy); end
        checks++; if (buf_we !== 1'b0) begin errors++; $error("FAIL empty_buf_we observed=%0h", buf_we); end
        checks++; if (ru_en !== 4'b0000) begin errors++; $error("FAIL empty_ru_en observed=%0h", ru_en); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL empty_done_off observed=%0h", done); end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL empty_busy_off observed=%0h", busy); end

        // Two reports, full pass with simultaneous completion.
        fault_valid = 1'b1; fault_row = 2'd1; fault_col = 2'd2;
        checks++; if (fault_ready !== 1'b1) begin errors++; $error("FAIL p1_ready observed=%0h", fault_ready); end
        tick();
        fault_row = 2'd3; fault_col = 2'd0;
        tick();
        fault_valid = 1'b0;
        checks++; if (num_faults !== 3'd2) begin errors++; $error("FAIL p1_num observed=%0h", num_faults); end
        checks++; if (ru_row[1] !== 2'd3) begin errors++; $error("FAIL p1_ru_row1 observed=%0h", ru_row[1]); end
        checks++; if (ru_col[0] !== 2'd2) begin errors++; $error("FAIL p1_ru_col0 observed=%0h", ru_col[0]); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (buf_we !== 1'b1) begin errors++; $error("FAIL p1_c1_we observed=%0h", buf_we); end
        checks++; if (buf_row !== 2'd1) begin errors++; $error("FAIL p1_c1_row observed=%0h", buf_row); end
        checks++; if (buf_col !== 2'd2) begin errors++; $error("FAIL p1_c1_col observed=%0h", buf_col); end
        checks++; if (fault_ready !== 1'b0) begin errors++; $error("FAIL p1_c1_ready observed=%0h", fault_ready); end
        tick();
        checks++; if (buf_we !== 1'b1) begin errors++; $error("FAIL p1_c2_we observed=%0h", buf_we); end
        checks++; if (buf_row !== 2'd3) begin errors++; $error("FAIL p1_c2_row observed=%0h", buf_row); end
        checks++; if (buf_col !== 2'd0) begin errors++; $error("FAIL p1_c2_col observed=%0h", buf_col); end
        tick();
        checks++; if (buf_we !== 1'b0) begin errors++; $error("FAIL p1_c3_we observed=%0h", buf_we); end
        checks++; if (ru_en !== 4'b0011) begin errors++; $error("FAIL p1_c3_en observed=%0h", ru_en); end
        ru_done = 4'b0011;
        tick(); ru_done = 4'b0000;
        checks++; if (ru_en !== 4'b0000) begin errors++; $error("FAIL p1_c4_en observed=%0h", ru_en); end
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL p1_c4_done observed=%0h", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $error("FAIL p1_c5_done observed=%0h", done); end
        checks++; if (busy !== 1'b1) begin errors++; $error("FAIL p1_c5_busy observed=%0h", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL p1_c6_done observed=%0h", done); end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL p1_c6_busy observed=%0h", busy); end

        // Retained table, staggered completion, ignored inputs while busy.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        tick();
        checks++; if (ru_en !== 4'b0011) begin errors++; $error("FAIL p2_c3_en observed=%0h", ru_en); end
        fault_valid = 1'b1; fault_row = 2'd3; fault_col = 2'd3;
        tick(); fault_valid = 1'b0;
        checks++; if (num_faults !== 3'd2) begin errors++; $error("FAIL p2_c4_num observed=%0h", num_faults); end
        checks++; if (overflow !== 1'b0) begin errors++; $error("FAIL p2_c4_ovf observed=%0h", overflow); end
        tick();
        ru_done = 4'b0001;
        checks++; if (ru_en !== 4'b0011) begin errors++; $error("FAIL p2_c5_en observed=%0h", ru_en); end
        tick(); ru_done = 4'b0000;
        checks++; if (ru_en !== 4'b0010) begin errors++; $error("FAIL p2_c6_en observed=%0h", ru_en); end
        tick();
        ru_done = 4'b1100;
        tick(); ru_done = 4'b0000;
        checks++; if (ru_en !== 4'b0010) begin errors++; $error("FAIL p2_c8_en observed=%0h", ru_en); end
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL p2_c8_done observed=%0h", done); end
        start = 1'b1;
        tick(); start = 1'b0;
        ru_done = 4'b0010;
        checks++; if (busy !== 1'b1) begin errors++; $error("FAIL p2_c9_busy observed=%0h", busy); end
        tick(); ru_done = 4'b0000;
        checks++; if (ru_en !== 4'b0000) begin errors++; $error("FAIL p2_c10_en observed=%0h", ru_en); end
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL p2_c10_done observed=%0h", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $error("FAIL p2_c11_done observed=%0h", done); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL p2_c12_busy observed=%0h", busy); end
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL p2_c12_done observed=%0h", done); end

        // Fill to capacity, then one more report overflows.
        fault_valid = 1'b1; fault_row = 2'd0; fault_col = 2'd1;
        tick();
        fault_row = 2'd2; fault_col = 2'd3;
        tick();
        checks++; if (fault_ready !== 1'b0) begin errors++; $error("FAIL ovf_ready observed=%0h", fault_ready); end
        checks++; if (num_faults !== 3'd4) begin errors++; $error("FAIL ovf_num4 observed=%0h", num_faults); end
        fault_row = 2'd3; fault_col = 2'd3;
        tick(); fault_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $error("FAIL ovf_flag observed=%0h", overflow); end
        checks++; if (num_faults !== 3'd4) begin errors++; $error("FAIL ovf_num observed=%0h", num_faults); end
        checks++; if (ru_row[2] !== 2'd0) begin errors++; $error("FAIL ovf_row2 observed=%0h", ru_row[2]); end
        checks++; if (ru_col[3] !== 2'd3) begin errors++; $error("FAIL ovf_col3 observed=%0h", ru_col[3]); end
        checks++; if (ru_row[3] !== 2'd2) begin errors++; $error("FAIL ovf_row3 observed=%0h", ru_row[3]); end

        // Reset during COMPUTE aborts the pass.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (ru_en !== 4'b1111) begin errors++; $error("FAIL abort_en_before observed=%0h", ru_en); end
        rst_n = 1'b0;
        #1;
        checks++; if (ru_en !== 4'b0000) begin errors++; $error("FAIL abort_en observed=%0h", ru_en); end
        checks++; if (num_faults !== 3'd0) begin errors++; $error("FAIL abort_num observed=%0h", num_faults); end
        checks++; if (overflow !== 1'b0) begin errors++; $error("FAIL abort_ovf observed=%0h", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL abort_busy observed=%0h", busy); end
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL abort_done observed=%0h", done); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $error("FAIL abort_post_done observed=%0h", done); end
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL abort_post_busy observed=%0h", busy); end

        // Duplicate reports.
        fault_valid = 1'b1; fault_row = 2'd2; fault_col = 2'd2;
        checks++; if (fault_ready !== 1'b1) begin errors++; $error("FAIL dup_ready observed=%0h", fault_ready); end
        tick(); tick();
        fault_valid = 1'b0;
        checks++; if (num_faults !== 3'(DUP_N)) begin errors++; $error("FAIL dup_num observed=%0h", num_faults); end
        checks++; if (overflow !== 1'b0) begin errors++; $error("FAIL dup_ovf observed=%0h", overflow); end

        // Report and start together: the new entry is part of this pass.
        fault_valid = 1'b1; fault_row = 2'd1; fault_col = 2'd1; start = 1'b1;
        tick();
        fault_valid = 1'b0; start = 1'b0;
        checks++; if (num_faults !== 3'(DUP_N + 1)) begin errors++; $error("FAIL both_num observed=%0h", num_faults); end
        checks++; if (buf_we !== 1'b1) begin errors++; $error("FAIL both_c1_we observed=%0h", buf_we); end
        checks++; if (buf_row !== 2'd2) begin errors++; $error("FAIL both_c1_row observed=%0h", buf_row); end
        for (int i = 1; i < DUP_N + 1; i++) tick();
        checks++; if (buf_we !== 1'b1) begin errors++; $error("FAIL both_last_we observed=%0h", buf_we); end
        checks++; if (buf_row !== 2'd1) begin errors++; $error("FAIL both_last_row observed=%0h", buf_row); end
        checks++; if (buf_col !== 2'd1) begin errors++; $error("FAIL both_last_col observed=%0h", buf_col); end
        tick();
        checks++; if (ru_en !== 4'((1 << (DUP_N + 1)) - 1)) begin errors++; $error("FAIL both_en observed=%0h", ru_en); end
        ru_done = 4'b1111;
        tick(); ru_done = 4'b0000;
        tick();
        checks++; if (done !== 1'b1) begin errors++; $error("FAIL both_done observed=%0h", done); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $error("FAIL both_idle observed=%0h", busy); end

        finished = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
